// File: rtl/kbd_matrix_mapper.sv
// kbd_matrix_mapper: emulates an NCOLS x NBANKS x BANK_BITS keyboard matrix
// fed from the ps2_key toggle bus. A runtime-loadable 512-entry map RAM
// translates {extended, scan code} into {valid, bank, col, bit}.
// Pipeline: detect edge latches the event and reads the map, the next edge
// updates key state, and the output register samples the next-state view,
// so a toggle shows on kbd_data_out two edges after it is detected.
// Optional build macro KBD_STICKY_EN: per-key sticky bits, set on press and
// cleared by rd_stb once the key is released, so short taps are never missed.
module kbd_matrix_mapper #(
    parameter int NCOLS     = 10,
    parameter int NBANKS    = 2,
    parameter int BANK_BITS = 4,
    parameter int DATA_LSB  = 4,
    parameter int CW        = (NCOLS > 1) ? $clog2(NCOLS) : 1,
    parameter int BW        = (NBANKS > 1) ? $clog2(NBANKS) : 1,
    parameter int KW        = (BANK_BITS > 1) ? $clog2(BANK_BITS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [10:0]            ps2_key,
    input  logic                   kbd_clear,
    input  logic [NCOLS-1:0]       col_sel,
    input  logic [BW-1:0]          bank_sel,
    input  logic                   rd_stb,
    input  logic                   map_we,
    input  logic [8:0]             map_addr,
    input  logic [1+BW+CW+KW-1:0]  map_data,
    output logic [7:0]             kbd_data_out
);

    localparam int MW    = 1 + BW + CW + KW;
    localparam int NKEYS = NBANKS * NCOLS * BANK_BITS;

    // Map RAM: survives reset, written by the loader, read by the lookup stage.
    logic [MW-1:0]        map_ram [512];
    logic [MW-1:0]        map_q_reg;

    logic                 tog_reg;
    logic                 s1_valid_reg;
    logic                 s1_pressed_reg;

    logic [NKEYS-1:0]     key_reg;
    logic [NKEYS-1:0]     key_next;
    logic [NKEYS-1:0]     vis_next;
    logic [BANK_BITS-1:0] hit;
    logic [7:0]           out_next;
    logic [7:0]           out_reg;

    logic                 event_det;
    logic                 ent_valid;
    logic [BW-1:0]        ent_bank;
    logic [CW-1:0]        ent_col;
    logic [KW-1:0]        ent_bit;
    logic                 upd_en;
    int                   upd_idx;

    assign event_det = ps2_key[10] ^ tog_reg;

    // Map RAM write port and registered lookup read (old data on same-address write).
    always_ff @(posedge clk) begin
        if (map_we) begin
            map_ram[map_addr] <= map_data;
        end
        map_q_reg <= map_ram[ps2_key[8:0]];
    end

    // Toggle history and stage-1 event latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tog_reg        <= ps2_key[10];
            s1_valid_reg   <= 1'b0;
            s1_pressed_reg <= 1'b0;
        end else begin
            tog_reg        <= ps2_key[10];
            s1_valid_reg   <= event_det;
            s1_pressed_reg <= ps2_key[9];
        end
    end

    // Decode the registered map entry and reject out-of-range targets.
    always_comb begin
        ent_valid = map_q_reg[MW-1];
        ent_bank  = map_q_reg[CW+KW +: BW];
        ent_col   = map_q_reg[KW +: CW];
        ent_bit   = map_q_reg[0 +: KW];
        upd_en    = s1_valid_reg && ent_valid
                    && (int'(ent_bank) < NBANKS)
                    && (int'(ent_col) < NCOLS)
                    && (int'(ent_bit) < BANK_BITS);
        upd_idx   = (int'(ent_bank) * NCOLS + int'(ent_col)) * BANK_BITS + int'(ent_bit);
    end

    // Key state next value: pipeline update, overridden by a global clear.
    always_comb begin
        key_next = key_reg;
        for (int i = 0; i < NKEYS; i++) begin
            if (upd_en && (i == upd_idx)) begin
                key_next[i] = s1_pressed_reg;
            end
        end
        if (kbd_clear) begin
            key_next = '0;
        end
    end

`ifdef KBD_STICKY_EN
    logic [NKEYS-1:0] sticky_reg;
    logic [NKEYS-1:0] sticky_next;

    // Sticky next value: read clears released keys, press sets (press wins), clear wins over all.
    always_comb begin
        sticky_next = sticky_reg;
        if (rd_stb) begin
            for (int bk = 0; bk < NBANKS; bk++) begin
                for (int c = 0; c < NCOLS; c++) begin
                    for (int b = 0; b < BANK_BITS; b++) begin
                        if ((int'(bank_sel) == bk) && !col_sel[c]
                            && !key_reg[(bk * NCOLS + c) * BANK_BITS + b]) begin
                            sticky_next[(bk * NCOLS + c) * BANK_BITS + b] = 1'b0;
                        end
                    end
                end
            end
        end
        for (int i = 0; i < NKEYS; i++) begin
            if (upd_en && s1_pressed_reg && (i == upd_idx)) begin
                sticky_next[i] = 1'b1;
            end
        end
        if (kbd_clear) begin
            sticky_next = '0;
        end
    end

    // Sticky storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sticky_reg <= '0;
        end else begin
            sticky_reg <= sticky_next;
        end
    end

    assign vis_next = key_next | sticky_next;
`else
    logic unused_rd_stb;
    assign unused_rd_stb = rd_stb;
    assign vis_next      = key_next;
`endif

    // Per key-bit OR across the selected columns of the selected bank.
    generate
        for (genvar gi = 0; gi < BANK_BITS; gi++) begin : g_hit
            always_comb begin
                hit[gi] = 1'b0;
                for (int bk = 0; bk < NBANKS; bk++) begin
                    for (int c = 0; c < NCOLS; c++) begin
                        if ((int'(bank_sel) == bk) && !col_sel[c]) begin
                            hit[gi] = hit[gi] | vis_next[(bk * NCOLS + c) * BANK_BITS + gi];
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_next = ~(8'(hit) << DATA_LSB);

    // Key state and registered active-low read mux output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_reg <= '0;
            out_reg <= 8'hFF;
        end else begin
            key_reg <= key_next;
            out_reg <= out_next;
        end
    end

    assign kbd_data_out = out_reg;

endmodule

// File: tb/tb_kbd_matrix_mapper.sv
// Self-checking bench for kbd_matrix_mapper: directed scenarios plus a random
// event stream, checked against a key-matrix reference model held in arrays.
module tb_kbd_matrix_mapper;

    localparam int NCOLS     = 10;
    localparam int NBANKS    = 2;
    localparam int BANK_BITS = 4;
    localparam int DATA_LSB  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] ps2_key = '0;
    logic        kbd_clear = 1'b0;
    logic [9:0]  col_sel = '1;
    logic [0:0]  bank_sel = '0;
    logic        rd_stb = 1'b0;
    logic        map_we = 1'b0;
    logic [8:0]  map_addr = '0;
    logic [7:0]  map_data = '0;
    logic [7:0]  kbd_data_out;

    int errors = 0;
    int checks = 0;

    // Reference model: map table as separate fields, key/sticky as 3-D bit arrays.
    bit mm_valid [512];
    int mm_bank  [512];
    int mm_col   [512];
    int mm_bit   [512];
    bit mk [NBANKS][NCOLS][BANK_BITS];
    bit ms [NBANKS][NCOLS][BANK_BITS];

    kbd_matrix_mapper dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_key      (ps2_key),
        .kbd_clear    (kbd_clear),
        .col_sel      (col_sel),
        .bank_sel     (bank_sel),
        .rd_stb       (rd_stb),
        .map_we       (map_we),
        .map_addr     (map_addr),
        .map_data     (map_data),
        .kbd_data_out (kbd_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] model_read(input logic [9:0] cs, input int bk);
        logic [7:0] r;
        r = 8'hFF;
        if (bk < NBANKS) begin
            for (int b = 0; b < BANK_BITS; b++)
                for (int c = 0; c < NCOLS; c++)
                    if (!cs[c] && (mk[bk][c][b] || ms[bk][c][b])) r[DATA_LSB+b] = 1'b0;
        end
        return r;
    endfunction

    function automatic void model_event(input bit p, input logic [8:0] a);
        int i;
        i = int'(a);
        if (mm_valid[i] && mm_bank[i] < NBANKS && mm_col[i] < NCOLS && mm_bit[i] < BANK_BITS) begin
            mk[mm_bank[i]][mm_col[i]][mm_bit[i]] = p;
`ifdef KBD_STICKY_EN
            if (p) ms[mm_bank[i]][mm_col[i]][mm_bit[i]] = 1'b1;
`endif
        end
    endfunction

    function automatic void model_clear();
        for (int bk = 0; bk < NBANKS; bk++)
            for (int c = 0; c < NCOLS; c++)
                for (int b = 0; b < BANK_BITS; b++) begin
                    mk[bk][c][b] = 1'b0;
                    ms[bk][c][b] = 1'b0;
                end
    endfunction

    function automatic void model_rd(input logic [9:0] cs, input int bk);
`ifdef KBD_STICKY_EN
        for (int c = 0; c < NCOLS; c++)
            for (int b = 0; b < BANK_BITS; b++)
                if (!cs[c] && !mk[bk][c][b]) ms[bk][c][b] = 1'b0;
`endif
    endfunction

    function automatic void model_map(input logic [8:0] a, input bit v, input int bk, input int col, input int bt);
        mm_valid[int'(a)] = v;
        mm_bank[int'(a)]  = bk;
        mm_col[int'(a)]   = col;
        mm_bit[int'(a)]   = bt;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a map write for one cycle (no ps2 toggle in that cycle).
    task automatic write_map(input logic [8:0] a, input logic v, input logic [0:0] bk,
                             input logic [3:0] col, input logic [1:0] bt);
        map_addr = a;
        map_data = {v, bk, col, bt};
        map_we   = 1'b1;
        tick();
        map_we   = 1'b0;
        model_map(a, v, int'(bk), int'(col), int'(bt));
    endtask

    // Flips the toggle strobe with a new event; the caller advances the clock.
    task automatic do_toggle(input logic p, input logic [8:0] a);
        ps2_key = {~ps2_key[10], p, a};
        model_event(p, a);
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        reset = 1'b0;
        tick();
        exp = 8'hFF;
        checks++;
        if (kbd_data_out !== exp) begin
            errors++;
            $display("FAIL reset_out: got %02h want %02h", kbd_data_out, exp);
        end
        tick();
        reset = 1'b1;
        col_sel = '0;
        bank_sel = 1'b0;
        model_clear();
        tick();
        exp = model_read(col_sel, 0);
        checks++;
        if (kbd_data_out !== exp) begin
            errors++;
            $display("FAIL reset_all_cols: got %02h want %02h", kbd_data_out, exp);
        end
        $display("test_reset: out=%02h", kbd_data_out);
    endtask

    task automatic test_basic_latency();
        write_map(9'h02D, 1'b1, 1'b0, 4'd2, 2'd0);
        col_sel  = ~(10'd1 << 2);
        bank_sel = 1'b0;
        tick();
        do_toggle(1'b1, 9'h02D);
        tick();
        checks++;
        if (kbd_data_out !== 8'hFF) begin
            errors++;
            $display("FAIL latency_early: got %02h want FF one edge after toggle", kbd_data_out);
        end
        tick();
        checks++;
        if (kbd_data_out !== 8'hEF) begin
            errors++;
            $display("FAIL latency_press: got %02h want EF two edges after toggle", kbd_data_out);
        end
        do_toggle(1'b0, 9'h02D);
        tick();
        tick();
        checks++;
        if (kbd_data_out !== 8'hFF) begin
            errors++;
            $display("FAIL latency_release: got %02h want FF", kbd_data_out);
        end
        $display("test_basic_latency: out=%02h", kbd_data_out);
    endtask

    task automatic test_extended();
        write_map(9'h075, 1'b1, 1'b0, 4'd0, 2'd1);
        write_map(9'h175, 1'b1, 1'b0, 4'd0, 2'd2);
        col_sel = ~10'd1;
        do_toggle(1'b1, 9'h175);
        tick(); tick(); tick();
        checks++;
        if (kbd_data_out !== 8'hBF) begin
            errors++;
            $display("FAIL ext_only: got %02h want BF", kbd_data_out);
        end
        do_toggle(1'b1, 9'h075);
        tick(); tick();
        checks++;
        if (kbd_data_out !== 8'h9F) begin
            errors++;
            $display("FAIL ext_both: got %02h want 9F", kbd_data_out);
        end
        do_toggle(1'b0, 9'h175);
        tick();
        do_toggle(1'b0, 9'h075);
        tick(); tick(); tick();
        checks++;
        if (kbd_data_out !== model_read(col_sel, 0)) begin
            errors++;
            $display("FAIL ext_release: got %02h want %02h", kbd_data_out, model_read(col_sel, 0));
        end
        $display("test_extended: out=%02h", kbd_data_out);
    endtask

    task automatic test_multi_col();
        write_map(9'h010, 1'b1, 1'b0, 4'd1, 2'd3);
        write_map(9'h011, 1'b1, 1'b0, 4'd4, 2'd0);
        do_toggle(1'b1, 9'h010);
        tick();
        do_toggle(1'b1, 9'h011);
        tick(); tick(); tick();
        col_sel = ~10'b00_0001_0010;
        tick();
        checks++;
        if (kbd_data_out !== 8'h6F) begin
            errors++;
            $display("FAIL multi_col_both: got %02h want 6F", kbd_data_out);
        end
        col_sel = ~10'b00_0000_0010;
        tick();
        checks++;
        if (kbd_data_out !== 8'h7F) begin
            errors++;
            $display("FAIL multi_col_one: got %02h want 7F", kbd_data_out);
        end
        $display("test_multi_col: out=%02h", kbd_data_out);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        write_map(9'h020, 1'b1, 1'b1, 4'd5, 2'd0);
        write_map(9'h021, 1'b1, 1'b1, 4'd6, 2'd2);
        write_map(9'h022, 1'b1, 1'b1, 4'd7, 2'd3);
        write_map(9'h023, 1'b0, 1'b1, 4'd8, 2'd1);
        write_map(9'h024, 1'b1, 1'b1, 4'd12, 2'd1);
        do_toggle(1'b1, 9'h020);
        tick();
        do_toggle(1'b1, 9'h021);
        tick();
        do_toggle(1'b1, 9'h022);
        tick(); tick(); tick();
        bank_sel = 1'b1;
        col_sel  = ~10'b00_1110_0000;
        tick();
        exp = model_read(col_sel, 1);
        checks++;
        if (kbd_data_out !== exp || kbd_data_out !== 8'h2F) begin
            errors++;
            $display("FAIL b2b_three: got %02h want %02h", kbd_data_out, exp);
        end
        do_toggle(1'b1, 9'h023);
        tick();
        do_toggle(1'b1, 9'h024);
        tick(); tick(); tick();
        col_sel = '0;
        tick();
        exp = model_read(col_sel, 1);
        checks++;
        if (kbd_data_out !== exp) begin
            errors++;
            $display("FAIL b2b_unmapped: got %02h want %02h", kbd_data_out, exp);
        end
        $display("test_back_to_back: out=%02h", kbd_data_out);
    endtask

    task automatic test_map_rbw();
        logic [7:0] exp;
        write_map(9'h030, 1'b1, 1'b0, 4'd8, 2'd1);
        // Lookup and rewrite of the same address in the same cycle.
        do_toggle(1'b1, 9'h030);
        map_addr = 9'h030;
        map_data = {1'b1, 1'b0, 4'd9, 2'd1};
        map_we   = 1'b1;
        tick();
        map_we = 1'b0;
        model_map(9'h030, 1'b1, 0, 9, 1);
        tick(); tick();
        bank_sel = 1'b0;
        col_sel  = ~(10'd1 << 8);
        tick();
        exp = model_read(col_sel, 0);
        checks++;
        if (kbd_data_out !== exp) begin
            errors++;
            $display("FAIL rbw_old_entry: got %02h want %02h", kbd_data_out, exp);
        end
        col_sel = ~(10'd1 << 9);
        tick();
        exp = model_read(col_sel, 0);
        checks++;
        if (kbd_data_out !== exp) begin
            errors++;
            $display("FAIL rbw_new_unset: got %02h want %02h", kbd_data_out, exp);
        end
        do_toggle(1'b1, 9'h030);
        tick(); tick(); tick();
        exp = model_read(col_sel, 0);
        checks++;
        if (kbd_data_out !== exp) begin
            errors++;
            $display("FAIL rbw_new_entry: got %02h want %02h", kbd_data_out, exp);
        end
        $display("test_map_rbw: out=%02h", kbd_data_out);
    endtask

    task automatic test_clear();
        col_sel = '0;
        do_toggle(1'b1, 9'h02D);
        tick();
        kbd_clear = 1'b1;
        model_clear();
        tick();
        kbd_clear = 1'b0;
        tick(); tick();
        for (int bk = 0; bk < NBANKS; bk++) begin
            bank_sel = bk[0:0];
            tick();
            checks++;
            if (kbd_data_out !== model_read(col_sel, bk) || kbd_data_out !== 8'hFF) begin
                errors++;
                $display("FAIL clear_bank%0d: got %02h want FF", bk, kbd_data_out);
            end
        end
        $display("test_clear: out=%02h", kbd_data_out);
    endtask

    task automatic test_reset_mid();
        bank_sel = 1'b0;
        col_sel  = ~(10'd1 << 2);
        do_toggle(1'b1, 9'h02D);
        tick();
        reset = 1'b0;
        // Toggle during reset must not be replayed afterwards.
        ps2_key = {~ps2_key[10], 1'b1, 9'h02D};
        tick();
        reset = 1'b1;
        model_clear();
        tick(); tick(); tick();
        checks++;
        if (kbd_data_out !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_flush: got %02h want FF", kbd_data_out);
        end
        do_toggle(1'b1, 9'h02D);
        tick(); tick();
        checks++;
        if (kbd_data_out !== 8'hEF) begin
            errors++;
            $display("FAIL reset_map_kept: got %02h want EF", kbd_data_out);
        end
        do_toggle(1'b0, 9'h02D);
        tick(); tick();
        $display("test_reset_mid: out=%02h", kbd_data_out);
    endtask

    task automatic test_sticky();
        logic [7:0] exp;
        write_map(9'h040, 1'b1, 1'b1, 4'd3, 2'd1);
        bank_sel = 1'b1;
        col_sel  = ~(10'd1 << 3);
        do_toggle(1'b1, 9'h040);
        tick();
        do_toggle(1'b0, 9'h040);
        tick(); tick(); tick();
        exp = model_read(col_sel, 1);
        checks++;
        if (kbd_data_out !== exp) begin
            errors++;
            $display("FAIL sticky_tap: got %02h want %02h", kbd_data_out, exp);
        end
        rd_stb = 1'b1;
        model_rd(col_sel, 1);
        tick();
        rd_stb = 1'b0;
        exp = model_read(col_sel, 1);
        checks++;
        if (kbd_data_out !== exp) begin
            errors++;
            $display("FAIL sticky_read_clear: got %02h want %02h", kbd_data_out, exp);
        end
        $display("test_sticky: out=%02h", kbd_data_out);
    endtask

    task automatic test_random();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            write_map(9'h100 + 9'(i), ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 11)), 2'($urandom_range(0, 3)));
        end
        for (int it = 0; it < 240; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
            end else begin
                do_toggle(1'($urandom_range(0, 1)), 9'h100 + 9'($urandom_range(0, 15)));
                tick();
            end
            if (it % 8 == 7) begin
                tick(); tick();
                col_sel  = 10'($urandom);
                bank_sel = 1'($urandom_range(0, 1));
                tick();
                exp = model_read(col_sel, int'(bank_sel));
                checks++;
                if (kbd_data_out !== exp) begin
                    errors++;
                    $display("FAIL random_read it=%0d: got %02h want %02h cs=%03h bank=%0d",
                             it, kbd_data_out, exp, col_sel, bank_sel);
                end else begin
                    $display("random it=%0d cs=%03h bank=%0d out=%02h", it, col_sel, bank_sel, kbd_data_out);
                end
            end
            if (it % 60 == 59) begin
                tick(); tick();
                kbd_clear = 1'b1;
                model_clear();
                tick();
                kbd_clear = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_extended();
        test_multi_col();
        test_back_to_back();
        test_map_rbw();
        test_clear();
        test_reset_mid();
        test_sticky();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kbd_matrix_mapper.md
Name: kbd_matrix_mapper

Overview:
- Parametrised successor to the fixed PS/2-to-matrix keyboard: emulates an N-column, multi-bank key matrix polled by the guest CPU through address-line column selects.
- Scan-code-to-matrix mapping lives in a runtime-loadable map RAM, so one block serves several machine layouts.
- Sits between the ps2_key bus from the HPS/IO layer and the CPU data-bus read mux.
- Adds extended-code (E0) discrimination, global key clear and an optional sticky-until-read mode.

Parameters:
- NCOLS, 10, number of column select lines (col_sel width).
- NBANKS, 2, number of row banks, chosen by bank_sel.
- BANK_BITS, 4, key bits per bank; 1..8-DATA_LSB.
- DATA_LSB, 4, kbd_data_out bit carrying key bit 0 of a bank.
- CW, $clog2(NCOLS), derived column index width.
- BW, $clog2(NBANKS) (min 1), derived bank index width.
- KW, $clog2(BANK_BITS) (min 1), derived key-bit index width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code.
- kbd_clear  in  1  one-cycle pulse: release all keys.
- col_sel  in  NCOLS  active-low column selects; several may be low at once.
- bank_sel  in  BW  bank being read.
- rd_stb  in  1  CPU read of the keyboard port this cycle.
- map_we  in  1  map RAM write strobe.
- map_addr  in  9  {extended, scan code}.
- map_data  in  1+BW+CW+KW  {valid, bank, col, bit}.
- kbd_data_out  out  8  registered active-low matrix data.

Behaviour:
- Reset (reset low at clk edge):
  - All key-state and sticky bits clear.
  - Toggle history register loads ps2_key[10], so a stale toggle is not replayed.
  - Lookup pipeline is flushed.
  - kbd_data_out becomes 8'hFF.
  - Map RAM contents are not cleared; the map survives reset.
- Event detect (cycle T): ps2_key[10] differs from the registered copy. Latch {pressed, ps2_key[8:0]} and issue a map RAM read at that address.
- Cycle T+1: the registered map entry is available.
  - valid=0, bank>=NBANKS, col>=NCOLS or bit>=BANK_BITS: event dropped, no state change.
  - Otherwise key[bank][col][bit] <= pressed.
- Cycle T+2: kbd_data_out reflects the new state. Fixed latency of 2 cycles from toggle to output.
- The extended bit is part of the address: E0 75 and 75 are distinct keys. Several codes may map to the same key; the last event wins.
- Back-to-back toggles on consecutive cycles are each processed. The pipeline is one event per cycle with no stall.
- Read mux, registered every cycle (not gated by rd_stb):
  - kbd_data_out[DATA_LSB+b] = ~OR over columns c with col_sel[c]==0 of key[bank_sel][c][b].
  - All other bits are 1.
  - No column selected gives 8'hFF. bank_sel>=NBANKS gives 8'hFF.
- Map write:
  - map_we writes in one cycle.
  - If a lookup reads the same address in the same cycle, the lookup gets the old entry (read-before-write).
  - A write never alters key state already set.
- kbd_clear clears all key and sticky bits on the next edge. If a pipeline update lands in the same cycle, the clear wins.
- No FSM beyond the 2-stage pipeline; it is a valid-bit shift, idle when no toggle is seen.

Optional Feature:
- Macro KBD_STICKY_EN.
- Defined:
  - Each key has a sticky bit, set on press.
  - The bit seen by the mux is key|sticky.
  - On rd_stb, every sticky bit in the selected bank and selected columns whose key is already released is cleared.
  - A tap shorter than the guest poll period is therefore seen exactly once.
  - A press and a read clearing the same key in the same cycle leaves sticky set.
- Undefined: no sticky storage; the mux sees the key bit only, and rd_stb is ignored.

Test Plan:
- Reset, then map 9'h02D -> {1, bank0, col2, bit0}. Toggle with code 2D pressed, col_sel=~(1<<2), bank_sel=0 -> kbd_data_out=8'hEF exactly 2 cycles after the toggle. Toggle released -> 8'hFF.
- Map 9'h075 -> col0 bit1 and 9'h175 -> col0 bit2. Press E0 75 only, select col0 -> 8'hBF. The non-extended key stays released.
- Press keys at bank0 col1 bit3 and col4 bit0. Drive col_sel with both lines low -> 8'h6F. Select col1 only -> 8'h7F.
- Toggles on 3 consecutive cycles for 3 different mapped keys -> all 3 bits active in the read. An unmapped code (valid=0) -> no change.
- Hold 2 keys, pulse kbd_clear in the same cycle as a third press update -> 8'hFF on all selects. Reset mid-press -> 8'hFF, and the map still decodes after reset.
- KBD_STICKY_EN: press then release before any rd_stb -> the bit still reads 0. The first rd_stb with that column selected -> the next cycle reads 1.
